uart_rx_deser: RTL and testbench



---
 rtl/uart_rx_deser.sv | 117 +++++++++++
 tb/tb_uart_rx_deser.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: double-synchronizes rx, checks start/stop framing and
// delivers LSB-first words over a valid/ready handshake with frame-error and overrun pulses.
module uart_rx_deser #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HalfM1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FullM1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LastBit = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 sync1_q;
   logic                 rx_s_q;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic                 frame_err_q;
   logic                 overrun_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync1_q     <= rx;
         rx_s_q      <= sync1_q;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         cnt_q       <= cnt_q + 1'b1;
         // A completion in the same cycle overrides this consume below.
         if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               bit_q <= '0;
               if (!rx_s_q) begin
                  state_q <= StStart;
               end
            end
            StStart: begin
               if (cnt_q == HalfM1) begin
                  cnt_q   <= '0;
                  state_q <= rx_s_q ? StIdle : StData;
               end
            end
            StData: begin
               if (cnt_q == FullM1) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == LastBit) begin
                     state_q <= StStop;
                  end
               end
            end
            StStop: begin
               if (cnt_q == FullM1) begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     state_q <= StIdle;
                     if (!rx_valid_q || rx_ready) begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= StBreak;
                  end
               end
            end
            StBreak: begin
               if (rx_s_q) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: framing, glitch rejection, break handling,
// overrun, same-cycle consume/complete and mid-frame reset.
module tb_uart_rx_deser;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   uart_rx_deser #(
      .CLKS_PER_BIT(16),
      .DATA_BITS   (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         vrise = 0;
   int         vhigh = 0;
   int         fe_high = 0;
   int         ov_high = 0;
   int         rise_cyc = 0;
   logic [7:0] last_data = 8'h00;
   logic       prev_v = 1'b0;

   always @(negedge clk) begin
      if (rx_valid === 1'b1 && !prev_v) begin
         vrise++;
         rise_cyc = cyc;
         last_data = rx_data;
      end
      if (rx_valid === 1'b1) vhigh++;
      if (frame_err === 1'b1) fe_high++;
      if (overrun === 1'b1) ov_high++;
      prev_v = (rx_valid === 1'b1);
   end

   int          start_cyc = 0;
   logic [10:0] snap = '1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   // Drives one 10-bit frame; optionally pulses rx_ready or rst on a given edge of it.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input int ready_edge, input int rst_edge);
      logic [9:0] line;
      int e;
      line = {stop_bit, d, 1'b0};
      start_cyc = cyc + 1;
      for (int j = 0; j < 10; j++) begin
         rx = line[j];
         for (int k = 0; k < 16; k++) begin
            e = 16 * j + k;
            if (ready_edge >= 0) rx_ready = (e == ready_edge);
            rst = (e != rst_edge);
            tick();
            if (e == rst_edge) snap = {rx_data, rx_valid, frame_err, overrun};
         end
      end
      rst = 1'b1;
   endtask

   int b_rise, b_high, b_fe, b_ov;

   initial begin
      rst = 1'b0;
      repeat (3) tick();
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_overrun", overrun, 1'b0);
      rst = 1'b1;
      idle(10);

      // 1: 0xA5 with ready held high
      rx_ready = 1'b1;
      b_rise = vrise; b_high = vhigh; b_fe = fe_high; b_ov = ov_high;
      send_frame(8'hA5, 1'b1, -1, -1);
      idle(4);
      check("t1_rises", vrise - b_rise, 1);
      check("t1_latency", rise_cyc - start_cyc, 154);
      check("t1_data", last_data, 8'hA5);
      check("t1_valid_cycles", vhigh - b_high, 1);
      check("t1_no_flags", (fe_high - b_fe) + (ov_high - b_ov), 0);

      // 2: 5-cycle glitch, then 0x3C
      b_rise = vrise; b_fe = fe_high;
      rx = 1'b0;
      repeat (5) tick();
      idle(30);
      check("t2_glitch_no_valid", vrise - b_rise, 0);
      check("t2_glitch_no_fe", fe_high - b_fe, 0);
      send_frame(8'h3C, 1'b1, -1, -1);
      idle(4);
      check("t2_rises", vrise - b_rise, 1);
      check("t2_data", last_data, 8'h3C);

      // 3: bad stop bit, line held low 40 more bit times, then 0xFF
      b_rise = vrise; b_fe = fe_high; b_ov = ov_high;
      send_frame(8'h00, 1'b0, -1, -1);
      rx = 1'b0;
      repeat (40 * 16) tick();
      idle(20);
      check("t3_frame_err_once", fe_high - b_fe, 1);
      check("t3_no_valid", vrise - b_rise, 0);
      check("t3_no_overrun", ov_high - b_ov, 0);
      send_frame(8'hFF, 1'b1, -1, -1);
      idle(4);
      check("t3_ff_rises", vrise - b_rise, 1);
      check("t3_ff_data", last_data, 8'hFF);
      check("t3_fe_total", fe_high - b_fe, 1);

      // 4: ready low, back-to-back 0x11 and 0x22
      rx_ready = 1'b0;
      b_rise = vrise; b_ov = ov_high; b_fe = fe_high;
      send_frame(8'h11, 1'b1, -1, -1);
      check("t4_first_data", rx_data, 8'h11);
      send_frame(8'h22, 1'b1, -1, -1);
      idle(4);
      check("t4_data_kept", rx_data, 8'h11);
      check("t4_valid_held", rx_valid, 1'b1);
      check("t4_overrun_once", ov_high - b_ov, 1);
      check("t4_rises", vrise - b_rise, 1);
      check("t4_no_fe", fe_high - b_fe, 0);
      rx_ready = 1'b1;
      tick();
      check("t4_valid_dropped", rx_valid, 1'b0);
      rx_ready = 1'b0;
      idle(4);

      // 5: ready pulsed on the completion edge of the second frame
      b_rise = vrise; b_ov = ov_high;
      send_frame(8'h55, 1'b1, -1, -1);
      check("t5_first_data", rx_data, 8'h55);
      send_frame(8'hAA, 1'b1, 154, -1);
      idle(4);
      check("t5_data", rx_data, 8'hAA);
      check("t5_valid_stays", rx_valid, 1'b1);
      check("t5_no_overrun", ov_high - b_ov, 0);
      check("t5_rises", vrise - b_rise, 1);

      // 6: reset during the last data bit of 0x5A, then 0x81
      b_rise = vrise; b_fe = fe_high;
      send_frame(8'h5A, 1'b1, -1, 140);
      check("t6_outputs_cleared", snap, 11'h000);
      idle(30);
      check("t6_no_valid", vrise - b_rise, 0);
      check("t6_no_fe", fe_high - b_fe, 0);
      send_frame(8'h81, 1'b1, -1, -1);
      idle(4);
      check("t6_rises", vrise - b_rise, 1);
      check("t6_data", rx_data, 8'h81);
      check("t6_valid", rx_valid, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
